best_arr_readout_ctrl: RTL and testbench
========================================

BEST_ARR_READOUT_CTRL -- requirements
Module: best_arr_readout_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 11: width of out FIFO write data.
REQ-002 Parameter IDX_WIDTH, default 9: width of a best-array entry (patch index).
REQ-003 Parameter ROW_SIZE, default 26: query columns per image row; shall be even.
REQ-004 Parameter COL_SIZE, default 19: query rows per image.
REQ-005 Parameter BLOCKING, default 4: columns per readout block.
REQ-006 Parameter BANK_ADDRW, default $clog2(COL_SIZE*ROW_SIZE/2) = 8: best-array per-bank address width.
REQ-007 Port clk, input, 1: single clock.
REQ-008 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 Port send_best_arr, input, 1: start pulse.
REQ-010 Port rd_en, output, 1: best-array read strobe.
REQ-011 Port rd_bank, output, 1: half-image bank select (px).
REQ-012 Port rd_addr, output, BANK_ADDRW: bank address.
REQ-013 Port rd_data, input, IDX_WIDTH: read data, valid exactly 1 cycle after rd_en.
REQ-014 Port out_fifo_wenq, output, 1: enqueue strobe.
REQ-015 Port out_fifo_wdata, output, DATA_WIDTH: rd_data zero-extended.
REQ-016 Port out_fifo_wfull_n, input, 1: FIFO not full.
REQ-017 Port out_qidx, output, IDX_WIDTH: linear query index of the word being enqueued.
REQ-018 Port busy, output, 1: high from the cycle after an accepted start until the cycle after done.
REQ-019 Port done, output, 1: one-cycle pulse, asserted in the cycle of the last enqueue.

Function
REQ-020 States: IDLE, RUN, DRAIN; IDLE->RUN on send_best_arr; RUN->DRAIN after the last read is issued; DRAIN->IDLE on the last enqueue.
REQ-021 send_best_arr outside IDLE shall be ignored, including in the done cycle.
REQ-022 Loop order, outermost first: px 0..1, x 0..XB-1, y 0..COL_SIZE-1, xi 0..BLOCKING-1, where XB = ceil((ROW_SIZE/2)/BLOCKING).
REQ-023 An iteration with x*BLOCKING+xi >= ROW_SIZE/2 shall be skipped with zero cycles consumed; defaults give XB=4 and only xi=0 in x=3.
REQ-024 Per issued read: rd_bank=px; rd_addr=y*(ROW_SIZE/2)+x*BLOCKING+xi; qidx=px*(ROW_SIZE/2)+y*ROW_SIZE+x*BLOCKING+xi.
REQ-025 qidx shall travel with the read through a 1-cycle pipeline, then a 2-entry output buffer; out_qidx and out_fifo_wdata come from the buffer head.
REQ-026 out_fifo_wenq shall equal (buffer non-empty AND out_fifo_wfull_n); each such cycle pops one entry.
REQ-027 A read shall issue only if (buffer occupancy + reads in flight) < 2 after the same-cycle pop; simultaneous pop and read-return shall be handled without loss.
REQ-028 Throughput shall be 1 word/cycle while out_fifo_wfull_n stays high; total words = COL_SIZE*ROW_SIZE (494 at defaults), each qidx exactly once.
REQ-029 Order shall be preserved; no words are dropped or duplicated under any out_fifo_wfull_n pattern.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE; all counters, buffer and pipeline cleared; rd_en, out_fifo_wenq, busy and done at 0; rd_bank, rd_addr, out_fifo_wdata and out_qidx at 0.
REQ-031 Reset mid-RUN shall abort without further enqueues; the next start after release shall restart from qidx 0.

Structure
REQ-032 The team package shall hold XB, BANK_ADDRW, the total word count and the state enum.
REQ-033 The 2-entry output buffer shall be a sub-module, readout_skid_buf (parameterised width, push/pop/occupancy).

Verification
REQ-034 Defaults, wfull_n=1, start pulse: first 8 out_qidx = 0,1,2,3,26,27,28,29; the word after y=18 of x=0 is qidx 4.
REQ-035 x=3 region: qidx sequence 12,38,64,... (stride 26) for 19 words, then 13,14,15,16,39 starting px=1.
REQ-036 Full run: exactly 494 enqueues; the qidx set equals 0..493; done is high one cycle on the 494th enqueue; busy falls the next cycle.
REQ-037 Hold wfull_n=0 for 10 cycles mid-run: zero enqueues; at most 2 words held or in flight; the sequence resumes intact after release.
REQ-038 Random wfull_n at 50%, rd_data=f(bank,addr) model: every out_fifo_wdata matches the model for its out_qidx.
REQ-039 Assert rst_n low after the 100th enqueue, restart: outputs zero during reset; the new run begins at qidx 0; a start pulse while busy has no effect.

Source files
------------

// File: rtl/best_arr_readout_ctrl_pkg.sv
// Shared constants and types for the best-array readout controller.
// Values here are the default-geometry figures.
package best_arr_readout_ctrl_pkg;

  localparam int ROW_SIZE_DEF = 26;
  localparam int COL_SIZE_DEF = 19;
  localparam int BLOCKING_DEF = 4;

  function automatic int calc_xb(input int row, input int blk);
    return ((row / 2) + blk - 1) / blk;
  endfunction

  localparam int XB = calc_xb(ROW_SIZE_DEF, BLOCKING_DEF);
  localparam int BANK_ADDRW =
    $clog2(COL_SIZE_DEF * ROW_SIZE_DEF / 2);
  localparam int TOTAL_WORDS = COL_SIZE_DEF * ROW_SIZE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/best_arr_readout_ctrl_skid.sv
// Two-entry in-order output buffer.
// Entry 0 is always the head; push and pop may coincide.
module readout_skid_buf #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  // next entries and occupancy for push/pop combinations
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head = e0_q;
  assign occ  = cnt_q;

endmodule

// File: rtl/best_arr_readout_ctrl.sv
// Streams the two-bank best array into the out FIFO,
// block-column order, tagging each word with its query index.
module best_arr_readout_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int BANK_ADDRW =
    $clog2(COL_SIZE * ROW_SIZE / 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_best_arr,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [BANK_ADDRW-1:0] rd_addr,
  input  logic [IDX_WIDTH-1:0]  rd_data,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n,
  output logic [IDX_WIDTH-1:0]  out_qidx,
  output logic                  busy,
  output logic                  done
);

  import best_arr_readout_ctrl_pkg::*;

  localparam int HALF = ROW_SIZE / 2;
  localparam int XBN  = calc_xb(ROW_SIZE, BLOCKING);
  localparam int XW   = $clog2(XBN + 1);
  localparam int YW   = $clog2(COL_SIZE + 1);
  localparam int IW   = $clog2(BLOCKING + 1);
  localparam int BW   = DATA_WIDTH + IDX_WIDTH;

  state_e              state_q, state_d;
  logic                px_q, px_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [IW-1:0]       xi_q, xi_d;
  logic                pvld_q, pvld_d;
  logic [IDX_WIDTH-1:0] pidx_q, pidx_d;

  logic [31:0]          col;
  logic [IDX_WIDTH-1:0] qidx_now;
  logic                 xi_end;
  logic                 last_iter;
  logic                 pop;
  logic [2:0]           room;
  logic [BW-1:0]        head;
  logic [1:0]           occ;

  assign col = 32'(x_q) * 32'(BLOCKING) + 32'(xi_q);
  assign rd_addr = BANK_ADDRW'(
    32'(y_q) * 32'(HALF) + col);
  assign qidx_now = IDX_WIDTH'(
    32'(px_q) * 32'(HALF) +
    32'(y_q) * 32'(ROW_SIZE) + col);
  assign rd_bank = px_q;

  // trailing out-of-row columns are skipped by ending the block early
  assign xi_end = (xi_q == IW'(BLOCKING - 1)) ||
                  (col + 32'd1 >= 32'(HALF));
  assign last_iter = px_q && xi_end &&
                     (y_q == YW'(COL_SIZE - 1)) &&
                     (x_q == XW'(XBN - 1));

  // a read may issue only if buffer plus flight stays below two
  assign pop  = (occ != 2'd0) && out_fifo_wfull_n;
  assign room = {1'b0, occ} - {2'b0, pop} + {2'b0, pvld_q};
  assign rd_en = (state_q == ST_RUN) && (room < 3'd2);

  assign out_fifo_wenq  = pop;
  assign out_fifo_wdata = head[IDX_WIDTH +: DATA_WIDTH];
  assign out_qidx       = head[IDX_WIDTH-1:0];
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DRAIN) && pop &&
                (occ == 2'd1) && !pvld_q;

  readout_skid_buf #(
    .W(BW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pvld_q),
    .push_data ({DATA_WIDTH'(rd_data), pidx_q}),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  // sequencing FSM, loop counters and read-return pipeline
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    x_d     = x_q;
    y_d     = y_q;
    xi_d    = xi_q;
    pvld_d  = rd_en;
    pidx_d  = rd_en ? qidx_now : pidx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (send_best_arr) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rd_en) begin
          if (last_iter) begin
            state_d = ST_DRAIN;
            px_d = 1'b0;
            x_d  = '0;
            y_d  = '0;
            xi_d = '0;
          end else if (!xi_end) begin
            xi_d = xi_q + 1'b1;
          end else begin
            xi_d = '0;
            if (y_q != YW'(COL_SIZE - 1)) begin
              y_d = y_q + 1'b1;
            end else begin
              y_d = '0;
              if (x_q != XW'(XBN - 1)) begin
                x_d = x_q + 1'b1;
              end else begin
                x_d  = '0;
                px_d = 1'b1;
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // controller registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      px_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xi_q    <= '0;
      pvld_q  <= 1'b0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xi_q    <= xi_d;
      pvld_q  <= pvld_d;
      pidx_q  <= pidx_d;
    end
  end

endmodule

// File: tb/tb_best_arr_readout_ctrl.sv
// Directed bench for best_arr_readout_ctrl.
// Memory model answers reads one cycle later.
module tb_best_arr_readout_ctrl;

  localparam int DW    = 11;
  localparam int IW    = 9;
  localparam int ROW   = 26;
  localparam int COL   = 19;
  localparam int BLK   = 4;
  localparam int AW    = 8;
  localparam int HALF  = 13;
  localparam int XBT   = 4;
  localparam int TOTAL = 494;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          send_best_arr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data = '0;
  logic          out_fifo_wenq;
  logic [DW-1:0] out_fifo_wdata;
  logic          out_fifo_wfull_n;
  logic [IW-1:0] out_qidx;
  logic          busy;
  logic          done;

  best_arr_readout_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .send_best_arr    (send_best_arr),
    .rd_en            (rd_en),
    .rd_bank          (rd_bank),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .out_fifo_wenq    (out_fifo_wenq),
    .out_fifo_wdata   (out_fifo_wdata),
    .out_fifo_wfull_n (out_fifo_wfull_n),
    .out_qidx         (out_qidx),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, act, exp);
    end
  endtask

  function automatic int mem_f(input int b, input int a);
    return (b * 97 + a * 5 + 3) % 512;
  endfunction

  function automatic int exp_data(input int q);
    int b, a;
    b = ((q % ROW) >= HALF) ? 1 : 0;
    a = (q / ROW) * HALF + (q % ROW) % HALF;
    return mem_f(b, a);
  endfunction

  always @(posedge clk)
    rd_data <= rd_en ?
      IW'(mem_f(int'(rd_bank), int'(rd_addr))) : '0;

  int exp_q [TOTAL];
  int got [$];
  int widx = 0;
  int n_rd = 0;
  int n_done = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  // scoreboard: every enqueue is checked against the loop order
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rd_en) n_rd++;
      if (out_fifo_wenq) begin
        if (widx < TOTAL) begin
          chk("qidx", int'(out_qidx), exp_q[widx]);
          chk("wdata", int'(out_fifo_wdata),
              exp_data(exp_q[widx]));
        end else begin
          chk("extra_word", widx, TOTAL - 1);
        end
        if (widx == 0) first_cyc = cyc;
        last_cyc = cyc;
        got.push_back(int'(out_qidx));
        widx++;
      end
      if (done) begin
        n_done++;
        chk("done_on_last", widx, TOTAL);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wenq"}, int'(out_fifo_wenq), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_bank"}, int'(rd_bank), 0);
    chk({tag, "_addr"}, int'(rd_addr), 0);
    chk({tag, "_qidx"}, int'(out_qidx), 0);
    chk({tag, "_wdata"}, int'(out_fifo_wdata), 0);
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    widx = 0;
    n_done = 0;
    n_rd = 0;
    got.delete();
    send_best_arr = 1'b1;
    @(posedge clk); #1;
    send_best_arr = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  // ends at negedge+1 of the done cycle
  task automatic wait_done(input bit rnd);
    int k;
    k = 0;
    while (n_done == 0 && k < 4000) begin
      @(posedge clk); #1;
      if (rnd) out_fifo_wfull_n = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      k++;
    end
    chk("done_seen", n_done, 1);
  endtask

  task automatic chk_set(input string tag);
    bit seen [TOTAL];
    int uniq;
    uniq = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (got[i])
      if (got[i] >= 0 && got[i] < TOTAL && !seen[got[i]]) begin
        seen[got[i]] = 1'b1;
        uniq++;
      end
    chk({tag, "_words"}, got.size(), TOTAL);
    chk({tag, "_unique"}, uniq, TOTAL);
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (widx < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_words", int'(widx >= n), 1);
  endtask

  initial begin
    int k, w0;
    int first8 [8] = '{0, 1, 2, 3, 26, 27, 28, 29};
    int tail5 [5] = '{13, 14, 15, 16, 39};
    k = 0;
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < XBT; x++)
        for (int y = 0; y < COL; y++)
          for (int xi = 0; xi < BLK; xi++)
            if (x * BLK + xi < HALF) begin
              exp_q[k] = px * HALF + y * ROW + x * BLK + xi;
              k++;
            end

    rst_n = 1'b0;
    send_best_arr = 1'b0;
    out_fifo_wfull_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    // run 1: full throughput, ordering landmarks
    start_run();
    wait_done(1'b0);
    send_best_arr = 1'b1;
    @(posedge clk); #1;
    send_best_arr = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1 chk("start_in_done_ignored", int'(busy), 0);
    chk("run1_done_cnt", n_done, 1);
    chk("run1_rate", last_cyc - first_cyc, TOTAL - 1);
    chk_set("run1");
    if (got.size() >= 252) begin
      foreach (first8[i])
        chk("first8", got[i], first8[i]);
      chk("after_y18", got[76], 4);
      for (int i = 0; i < 19; i++)
        chk("x3_col", got[228 + i], 12 + 26 * i);
      foreach (tail5[i])
        chk("px1_head", got[247 + i], tail5[i]);
    end else begin
      chk("run1_len", got.size(), TOTAL);
    end

    // run 2: stall window, start while busy, random backpressure
    start_run();
    wait_words(50);
    out_fifo_wfull_n = 1'b0;
    send_best_arr = 1'b1;
    w0 = widx;
    @(posedge clk); #1;
    send_best_arr = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("stall_no_enq", widx, w0);
    chk("stall_held_le2", int'((n_rd - widx) <= 2), 1);
    chk("stall_busy", int'(busy), 1);
    wait_done(1'b1);
    out_fifo_wfull_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("run2_done_cnt", n_done, 1);
    chk_set("run2");
    chk("run2_idle", int'(busy), 0);

    // run 3: reset mid-run, then restart from zero
    start_run();
    wait_words(100);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(negedge clk);
    chk_zero("midrst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_run();
    wait_done(1'b0);
    chk_set("run3");
    if (got.size() > 0) chk("run3_first", got[0], 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
